cdb_wb_arbiter: RTL



---
 rtl/cdb_wb_arbiter_if.sv | 50 +++++
 rtl/cdb_wb_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cdb_wb_arbiter_if.sv
// Writeback bus bundle: ALU result slot, MEM writeback port, CDB broadcast and status.
// The arbiter connects through "slave"; the producing/consuming side uses "master".
interface cdb_wb_arbiter_if;
    logic         Valid_ALU_CDB;
    logic [7:0]   ActiveMask_ALU_CDB;
    logic [31:0]  Instr_ALU_CDB;
    logic [2:0]   WarpID_ALU_CDB;
    logic         RegWrite_ALU_CDB;
    logic [4:0]   Dst_ALU_CDB;
    logic [255:0] Dst_Data_ALU_CDB;

    logic         Valid_MEM_CDB;
    logic         Ready_CDB_MEM;
    logic [7:0]   ActiveMask_MEM_CDB;
    logic [31:0]  Instr_MEM_CDB;
    logic [2:0]   WarpID_MEM_CDB;
    logic         RegWrite_MEM_CDB;
    logic [4:0]   Dst_MEM_CDB;
    logic [255:0] Dst_Data_MEM_CDB;

    logic         Stall_CDB_OC;
    logic         Valid_CDB;
    logic [7:0]   ActiveMask_CDB;
    logic [31:0]  Instr_CDB;
    logic [2:0]   WarpID_CDB;
    logic         RegWrite_CDB;
    logic [4:0]   Dst_CDB;
    logic [255:0] Dst_Data_CDB;
    logic         Overflow_Err;

    modport slave (
        input  Valid_ALU_CDB, ActiveMask_ALU_CDB, Instr_ALU_CDB, WarpID_ALU_CDB,
               RegWrite_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB,
        input  Valid_MEM_CDB, ActiveMask_MEM_CDB, Instr_MEM_CDB, WarpID_MEM_CDB,
               RegWrite_MEM_CDB, Dst_MEM_CDB, Dst_Data_MEM_CDB,
        output Ready_CDB_MEM, Stall_CDB_OC,
        output Valid_CDB, ActiveMask_CDB, Instr_CDB, WarpID_CDB, RegWrite_CDB,
               Dst_CDB, Dst_Data_CDB, Overflow_Err
    );

    modport master (
        output Valid_ALU_CDB, ActiveMask_ALU_CDB, Instr_ALU_CDB, WarpID_ALU_CDB,
               RegWrite_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB,
        output Valid_MEM_CDB, ActiveMask_MEM_CDB, Instr_MEM_CDB, WarpID_MEM_CDB,
               RegWrite_MEM_CDB, Dst_MEM_CDB, Dst_Data_MEM_CDB,
        input  Ready_CDB_MEM, Stall_CDB_OC,
        input  Valid_CDB, ActiveMask_CDB, Instr_CDB, WarpID_CDB, RegWrite_CDB,
               Dst_CDB, Dst_Data_CDB, Overflow_Err
    );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// CDB writeback arbiter: buffers non-stallable ALU results in a FIFO and shares the
// single CDB with the MEM port, forcing a MEM grant after MEM_MAX_WAIT refusals.
module cdb_wb_arbiter #(
    parameter int ALU_FIFO_DEPTH = 4,
    parameter int MEM_MAX_WAIT   = 3
) (
    input logic             clk,
    input logic             rst,
    cdb_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(ALU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(MEM_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(ALU_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STALL_C = CNT_W'(ALU_FIFO_DEPTH - 1);
    localparam logic [STV_W-1:0] MAXW_C  = STV_W'(MEM_MAX_WAIT);

    typedef struct packed {
        logic [7:0]   mask;
        logic [31:0]  instr;
        logic [2:0]   warp;
        logic         rw;
        logic [4:0]   dst;
        logic [255:0] data;
    } result_t;

    result_t              mem_q [ALU_FIFO_DEPTH];
    result_t              mem_d [ALU_FIFO_DEPTH];
    result_t              cdb_q, cdb_d;
    logic                 cdb_vld_q, cdb_vld_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [STV_W-1:0]     starve_q, starve_d;

    result_t alu_res, mem_res;
    logic    alu_push, alu_pend, force_mem, grant_alu, grant_mem;
    logic    fifo_full, push_ok, push_drop;

    assign alu_res = '{mask: bus.ActiveMask_ALU_CDB, instr: bus.Instr_ALU_CDB,
                       warp: bus.WarpID_ALU_CDB, rw: bus.RegWrite_ALU_CDB,
                       dst: bus.Dst_ALU_CDB, data: bus.Dst_Data_ALU_CDB};
    assign mem_res = '{mask: bus.ActiveMask_MEM_CDB, instr: bus.Instr_MEM_CDB,
                       warp: bus.WarpID_MEM_CDB, rw: bus.RegWrite_MEM_CDB,
                       dst: bus.Dst_MEM_CDB, data: bus.Dst_Data_MEM_CDB};

    always_comb begin
        alu_push  = bus.Valid_ALU_CDB & bus.RegWrite_ALU_CDB;
        alu_pend  = (count_q != '0);
        force_mem = bus.Valid_MEM_CDB & (starve_q == MAXW_C);
        grant_alu = alu_pend & ~force_mem;
        grant_mem = bus.Valid_MEM_CDB & ~grant_alu;
        fifo_full = (count_q == DEPTH_C);
        // A simultaneous pop frees the head slot, so a push into a full FIFO is still safe.
        push_ok   = alu_push & (~fifo_full | grant_alu);
        push_drop = alu_push & fifo_full & ~grant_alu;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | push_drop;
        if (push_ok) begin
            mem_d[wr_ptr_q] = alu_res;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (grant_alu) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, grant_alu})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = '0;
        if (bus.Valid_MEM_CDB & ~grant_mem) begin
            starve_d = (starve_q == MAXW_C) ? starve_q : starve_q + 1'b1;
        end
    end

    // CDB fields hold when nothing is granted; only the valid bit drops.
    always_comb begin
        cdb_d     = cdb_q;
        cdb_vld_d = 1'b0;
        if (grant_alu) begin
            cdb_d     = mem_q[rd_ptr_q];
            cdb_vld_d = 1'b1;
        end else if (grant_mem) begin
            cdb_d     = mem_res;
            cdb_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= '0;
            cdb_q     <= '0;
            cdb_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            starve_q  <= starve_d;
            cdb_q     <= cdb_d;
            cdb_vld_q <= cdb_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.Ready_CDB_MEM  = grant_mem;
    assign bus.Stall_CDB_OC   = (count_q >= STALL_C);
    assign bus.Valid_CDB      = cdb_vld_q;
    assign bus.ActiveMask_CDB = cdb_q.mask;
    assign bus.Instr_CDB      = cdb_q.instr;
    assign bus.WarpID_CDB     = cdb_q.warp;
    assign bus.RegWrite_CDB   = cdb_q.rw;
    assign bus.Dst_CDB        = cdb_q.dst;
    assign bus.Dst_Data_CDB   = cdb_q.data;
    assign bus.Overflow_Err   = ovf_q;
endmodule
